// File: rtl/apb_pkg.sv
// Shared APB definitions for the master bridge and its neighbouring slave.
//   - apb_state_e : transfer phase encoding (IDLE=00, SETUP=01, ACCESS=10),
//                   identical to the slave so traces line up.
//   - APB_ADDR_W / APB_DATA_W : default bus widths.
//   - apb_rsp_t   : one completed-transfer response {rdata, err, timeout}.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// APB master bridge: converts a valid/ready request stream into APB
// SETUP->ACCESS transfers and returns exactly one response per request.
// Only one transfer is ever in flight.
//
// Ports
//   PCLK, PRESETn                 clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_addr/req_write/req_wdata  request payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err/rsp_timeout response payload (rdata is 0 for writes)
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA  APB requester outputs (all registered)
//   PRDATA/PREADY/PSLVERR         APB completer inputs
//
// Build option
//   APB_MASTER_TIMEOUT_EN : abort an ACCESS phase that sees no PREADY for
//   TIMEOUT_CYCLES cycles. Without it the bridge waits indefinitely and
//   rsp_timeout is tied low.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept;
  logic              timeout_hit;

  // Accept only when idle and the previous response has drained; this also
  // guarantees PSEL spends at least one cycle low between transfers.
  assign req_ready = (state_q == IDLE) && !rsp_valid_q;
  assign accept    = req_valid && req_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] tcnt_q, tcnt_d;
  logic       rsp_timeout_q, rsp_timeout_d;

  // tcnt_q holds the number of stalled ACCESS cycles already elapsed, so the
  // abort fires at the end of the TIMEOUT_CYCLES-th stalled cycle.
  assign timeout_hit = (state_q == ACCESS) && !PREADY &&
                       (tcnt_q >= 8'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_timeout_q;

  always_comb begin
    tcnt_d        = tcnt_q;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q == SETUP) begin
      tcnt_d = '0;
    end else if ((state_q == ACCESS) && !PREADY && !timeout_hit) begin
      tcnt_d = tcnt_q + 8'd1;
    end
    // PREADY in the abort cycle means a normal completion.
    if ((state_q == ACCESS) && (PREADY || timeout_hit)) begin
      rsp_timeout_d = !PREADY;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt_q        <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tcnt_q        <= tcnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; PREADY is looked at only in ACCESS
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pwdata_d  = req_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY || timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          // A timeout reports an error with zero data.
          rsp_err_d   = PREADY ? PSLVERR : 1'b1;
          rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream neighbour of the APB memory slave. Turns a simple valid/ready request stream (addr, write, wdata) into compliant APB SETUP→ACCESS transfers.
- Waits on PREADY, captures PRDATA/PSLVERR, and returns a single response per request on a valid/ready response channel.
- One outstanding transfer at a time. Sits between the bus-functional/host logic and the APB slave.

Parameters:
- ADDR_W, 32, width of req_addr and PADDR
- DATA_W, 32, width of req_wdata, PWDATA, PRDATA, rsp_rdata
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles without PREADY; used only with the optional feature; legal range 1..255

Ports:
- PCLK  in  1  bus clock; all logic on its rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_addr  in  ADDR_W  transfer address
- req_write  in  1  1=write, 0=read
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout (tied 0 without feature)
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset: asynchronous on PRESETn low. State=IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout=0; PADDR, PWDATA, rsp_rdata=0; timeout counter=0. All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- req_ready = (state==IDLE) && !rsp_valid. It is combinational from registers only, never from req_valid.
- IDLE: on req_valid && req_ready, register PADDR/PWRITE/PWDATA from the request, set PSEL=1, PENABLE=0, go to SETUP.
- SETUP: lasts exactly one cycle. Set PENABLE=1, go to ACCESS. PADDR/PWRITE/PWDATA stay stable until the transfer ends.
- ACCESS: PREADY is sampled only in this state; PREADY during SETUP is ignored.
  - PREADY=0: hold all APB outputs.
  - PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA and rsp_err = PSLVERR; set rsp_valid=1; drop PSEL and PENABLE; go to IDLE.
- Latency: request accepted at edge N, SETUP in cycle N+1, ACCESS from N+2. With zero wait states, rsp_valid=1 after edge N+3.
- Response channel: rsp_valid and the response fields hold until rsp_valid && rsp_ready, then rsp_valid clears on that edge. A new request is not accepted in the same cycle the response drains; it can be accepted from the following cycle.
- No back-to-back transfers: PSEL is low for at least one cycle between transfers.
- Reset mid-transfer: PSEL/PENABLE drop immediately (asynchronous); the pending request is lost and no response is produced.
- req_* inputs are ignored while req_ready=0.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts: PSEL/PENABLE drop, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to IDLE. If PREADY=1 in that same cycle, normal completion wins.
- Not defined: no counter; the bridge waits in ACCESS indefinitely; rsp_timeout is tied 0.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS} (2-bit encodings 00/01/10, matching the slave)
  - default ADDR_W/DATA_W constants
  - response struct {rdata, err, timeout}
- No sub-module. The FSM, capture register and timeout counter stay in one module.

Test Plan:
- Write addr 0x04 data 0xDEADBEEF, slave PREADY in first ACCESS cycle → PSEL high 2 cycles, PENABLE high 1 cycle, PWRITE=1, rsp_valid after 3 edges, rsp_err=0, rsp_rdata=0.
- Read addr 0x04 after that write → rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read addr 0x40 (slave flags PSLVERR) → rsp_err=1, rsp_timeout=0; PADDR stays 0x40 through ACCESS.
- Three PREADY wait states on write addr 0x10 → PENABLE high 4 cycles, PADDR/PWDATA stable throughout; hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready=0.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY held 0 → abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1. Without the macro, PENABLE is still high after 100 cycles.
- PRESETn pulsed low during ACCESS → PSEL/PENABLE=0 before the next clock edge, rsp_valid=0, req_ready=1 after release.
